// File: rtl/upgrade_pkg.sv
// upgrade_pkg: shared state/player types, counter width and bit-reverse helper for the upgrade scheduler
package upgrade_pkg;

    typedef enum logic [1:0] {COOLDOWN, SPAWN, ACTIVE, EFFECT} upg_state_t;
    typedef enum logic {P1, P2} player_t;

    localparam int CNT_W = 12;

    function automatic logic [9:0] bit_rev10(input logic [9:0] v);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = v[9 - i];
        return r;
    endfunction

endpackage

// File: rtl/upgrade_hit_detect.sv
// upgrade_hit_detect: box overlap between one ball and the upgrade sprite, widened to 11 bits so edge positions never wrap
module upgrade_hit_detect #(
    parameter int UPG_SIZE = 4
) (
    input  logic [9:0] i_ball_x,
    input  logic [9:0] i_ball_y,
    input  logic [9:0] i_ball_size,
    input  logic [9:0] i_upg_x,
    input  logic [9:0] i_upg_y,
    output logic       o_hit
);

    logic [10:0] w_lim;
    logic [10:0] w_dx;
    logic [10:0] w_dy;

    assign w_lim = {1'b0, i_ball_size} + 11'(UPG_SIZE);
    assign w_dx  = (i_ball_x >= i_upg_x) ? {1'b0, i_ball_x} - {1'b0, i_upg_x} : {1'b0, i_upg_x} - {1'b0, i_ball_x};
    assign w_dy  = (i_ball_y >= i_upg_y) ? {1'b0, i_ball_y} - {1'b0, i_upg_y} : {1'b0, i_upg_y} - {1'b0, i_ball_y};
    assign o_hit = (w_dx <= w_lim) && (w_dy <= w_lim);

endmodule

// File: rtl/upgrade_scheduler.sv
// upgrade_scheduler: cooldown -> spawn -> collect -> timed speed grant cycle for one shared upgrade; UPGRADE_TIMEOUT_EN adds a despawn timeout
module upgrade_scheduler
    import upgrade_pkg::*;
#(
    parameter int         COOLDOWN_FRAMES = 180,
    parameter int         EFFECT_FRAMES   = 300,
    parameter int         DESPAWN_FRAMES  = 600,
    parameter int         X_MIN           = 40,
    parameter int         X_MAX           = 600,
    parameter int         Y_MIN           = 40,
    parameter int         Y_MAX           = 440,
    parameter int         UPG_SIZE        = 4,
    parameter logic [9:0] LFSR_SEED       = 10'h2A5
) (
    input  logic             frame_clk,
    input  logic             Reset_n,
    input  logic             game_en,
    input  logic [9:0]       BallX,
    input  logic [9:0]       BallY,
    input  logic [9:0]       Ball2X,
    input  logic [9:0]       Ball2Y,
    input  logic [9:0]       Ball_Size,
    output logic [9:0]       UpgradeX,
    output logic [9:0]       UpgradeY,
    output logic             upgrade_visible,
    output logic             speed_1_upgraded,
    output logic             speed_2_upgraded,
    output logic [CNT_W-1:0] effect_left,
    output logic             was_collected
);

    localparam logic [CNT_W-1:0] L_CD  = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0] L_EF  = CNT_W'(EFFECT_FRAMES);
    localparam logic [CNT_W-1:0] L_DS  = CNT_W'(DESPAWN_FRAMES);
    localparam logic [9:0]       L_XLO = 10'(X_MIN);
    localparam logic [9:0]       L_XHI = 10'(X_MAX);
    localparam logic [9:0]       L_YLO = 10'(Y_MIN);
    localparam logic [9:0]       L_YHI = 10'(Y_MAX);

    upg_state_t       r_state, w_state;
    player_t          r_last, w_last;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [9:0]       r_lfsr;
    logic [9:0]       w_x, w_y, w_cand_y;
    logic             w_col, w_hit1, w_hit2, w_in_bounds;

    assign w_cand_y    = bit_rev10(r_lfsr);
    assign w_in_bounds = (r_lfsr >= L_XLO) && (r_lfsr <= L_XHI) && (w_cand_y >= L_YLO) && (w_cand_y <= L_YHI);

    upgrade_hit_detect #(.UPG_SIZE(UPG_SIZE)) u_hit1 (
        .i_ball_x(BallX), .i_ball_y(BallY), .i_ball_size(Ball_Size),
        .i_upg_x(UpgradeX), .i_upg_y(UpgradeY), .o_hit(w_hit1)
    );

    upgrade_hit_detect #(.UPG_SIZE(UPG_SIZE)) u_hit2 (
        .i_ball_x(Ball2X), .i_ball_y(Ball2Y), .i_ball_size(Ball_Size),
        .i_upg_x(UpgradeX), .i_upg_y(UpgradeY), .o_hit(w_hit2)
    );

    // Next state: round sequencing, winner arbitration (round-robin on ties) and game_en override
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_last  = r_last;
        w_x     = UpgradeX;
        w_y     = UpgradeY;
        w_col   = 1'b0;
        case (r_state)
            COOLDOWN: begin
                if (r_cnt != '0) w_cnt = r_cnt - 1'b1;
                else if (game_en) w_state = SPAWN;
            end
            SPAWN: begin
                if (w_in_bounds) begin
                    w_state = ACTIVE;
                    w_cnt   = L_DS;
                    w_x     = r_lfsr;
                    w_y     = w_cand_y;
                end
            end
            ACTIVE: begin
                if (w_hit1 || w_hit2) begin
                    w_last  = (w_hit1 && w_hit2) ? ((r_last == P1) ? P2 : P1) : (w_hit1 ? P1 : P2);
                    w_col   = 1'b1;
                    w_state = EFFECT;
                    w_cnt   = L_EF;
                end
`ifdef UPGRADE_TIMEOUT_EN
                else if (r_cnt <= 1) begin
                    w_state = COOLDOWN;
                    w_cnt   = L_CD;
                end else w_cnt = r_cnt - 1'b1;
`endif
            end
            EFFECT: begin
                if (r_cnt <= 1) begin
                    w_state = COOLDOWN;
                    w_cnt   = L_CD;
                end else w_cnt = r_cnt - 1'b1;
            end
            default: ;
        endcase
        if (!game_en) begin
            w_state = COOLDOWN;
            w_cnt   = L_CD;
            w_last  = r_last;
            w_col   = 1'b0;
        end
    end

    // State, LFSR and registered outputs derived from the next state
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state          <= COOLDOWN;
            r_cnt            <= L_CD;
            r_lfsr           <= LFSR_SEED;
            r_last           <= P2;
            UpgradeX         <= '0;
            UpgradeY         <= '0;
            upgrade_visible  <= 1'b0;
            speed_1_upgraded <= 1'b0;
            speed_2_upgraded <= 1'b0;
            effect_left      <= '0;
            was_collected    <= 1'b0;
        end else begin
            r_state          <= w_state;
            r_cnt            <= w_cnt;
            r_lfsr           <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
            r_last           <= w_last;
            UpgradeX         <= w_x;
            UpgradeY         <= w_y;
            upgrade_visible  <= (w_state == ACTIVE);
            speed_1_upgraded <= (w_state == EFFECT) && (w_last == P1);
            speed_2_upgraded <= (w_state == EFFECT) && (w_last == P2);
            effect_left      <= (w_state == EFFECT) ? w_cnt : '0;
            was_collected    <= w_col;
        end
    end

endmodule

// File: tb/tb_upgrade_scheduler.sv
// tb_upgrade_scheduler: scoreboard bench for upgrade_scheduler; covers the UPGRADE_TIMEOUT_EN build when that macro is set
module tb_upgrade_scheduler;

    localparam int CF = 4;
    localparam int EF = 300;
    localparam int DF = 8;
    localparam int K_SPAWN = 0;
    localparam int K_GRANT = 1;
    localparam int K_END   = 2;

    typedef struct {
        int kind;
        int at;
        int a;
        int b;
    } ev_t;

    logic        frame_clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        game_en = 1'b1;
    logic [9:0]  BallX, BallY, Ball2X, Ball2Y, Ball_Size;
    logic [9:0]  UpgradeX, UpgradeY;
    logic        upgrade_visible, speed_1_upgraded, speed_2_upgraded, was_collected;
    logic [11:0] effect_left;

    int   vectors = 0;
    int   errors = 0;
    int   edge_n;
    ev_t  expq[$];
    logic [9:0] lf [0:8191];
    logic prev_vis = 1'b0;
    logic prev_fl = 1'b0;

    upgrade_scheduler #(
        .COOLDOWN_FRAMES(CF),
        .EFFECT_FRAMES(EF),
        .DESPAWN_FRAMES(DF)
    ) dut (
        .frame_clk(frame_clk),
        .Reset_n(Reset_n),
        .game_en(game_en),
        .BallX(BallX),
        .BallY(BallY),
        .Ball2X(Ball2X),
        .Ball2Y(Ball2Y),
        .Ball_Size(Ball_Size),
        .UpgradeX(UpgradeX),
        .UpgradeY(UpgradeY),
        .upgrade_visible(upgrade_visible),
        .speed_1_upgraded(speed_1_upgraded),
        .speed_2_upgraded(speed_2_upgraded),
        .effect_left(effect_left),
        .was_collected(was_collected)
    );

    always #5 frame_clk = ~frame_clk;

    always @(posedge frame_clk or negedge Reset_n)
        if (!Reset_n) edge_n <= 0;
        else edge_n <= edge_n + 1;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, exp, edge_n);
        end
    endtask

    task automatic check_ev(input int kind, input int a, input int b);
        ev_t e;
        vectors++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d edge=%0d a=%0d b=%0d, expected none", kind, edge_n, a, b);
        end else begin
            e = expq.pop_front();
            if (e.kind != kind || e.at != edge_n || e.a != a || e.b != b) begin
                errors++;
                $display("FAIL event: got kind=%0d edge=%0d a=%0d b=%0d, expected kind=%0d edge=%0d a=%0d b=%0d",
                         kind, edge_n, a, b, e.kind, e.at, e.a, e.b);
            end
        end
    endtask

    task automatic push(input int kind, input int at, input int a, input int b);
        ev_t e;
        e.kind = kind;
        e.at = at;
        e.a = a;
        e.b = b;
        expq.push_back(e);
    endtask

    // Monitor: turns output transitions into events and matches them against the scoreboard
    always @(negedge frame_clk) begin
        if (Reset_n) begin
            if (upgrade_visible && !prev_vis) check_ev(K_SPAWN, int'(UpgradeX), int'(UpgradeY));
            if (was_collected) check_ev(K_GRANT, int'(speed_1_upgraded), int'(speed_2_upgraded));
            if (prev_fl && !(speed_1_upgraded || speed_2_upgraded)) check_ev(K_END, int'(effect_left), 0);
        end
        prev_vis <= upgrade_visible;
        prev_fl  <= speed_1_upgraded || speed_2_upgraded;
    end

    task automatic wait_edge(input int e);
        while (edge_n < e) @(negedge frame_clk);
    endtask

    task automatic park();
        BallX = 10'd1000;
        BallY = 10'd1000;
        Ball2X = 10'd1000;
        Ball2Y = 10'd1000;
    endtask

    function automatic int rev10(input logic [9:0] v);
        int r = 0;
        for (int i = 0; i < 10; i++) if (v[i]) r += 1 << (9 - i);
        return r;
    endfunction

    // Cooldown holds cnt=CF after edge c; SPAWN entered at edge c+CF+1 tests lf[c+CF+1] at the next edge
    task automatic expect_spawn(input int c, output int ev, output int x, output int y);
        int k = c + CF + 1;
        x = int'(lf[k]);
        y = rev10(lf[k]);
        while (!(x >= 40 && x <= 600 && y >= 40 && y <= 440) && k < 8190) begin
            k++;
            x = int'(lf[k]);
            y = rev10(lf[k]);
        end
        ev = k + 1;
        push(K_SPAWN, ev, x, y);
        wait_edge(ev);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, ev, ec, x, y;
        lf[0] = 10'h2A5;
        for (int k = 0; k < 8191; k++) lf[k+1] = {lf[k][8:0], lf[k][10-1] ^ lf[k][7-1]};
        Ball_Size = 10'd4;
        park();
        #12;
        chk("rst_upgx", int'(UpgradeX), 0);
        chk("rst_upgy", int'(UpgradeY), 0);
        chk("rst_visible", int'(upgrade_visible), 0);
        chk("rst_speed1", int'(speed_1_upgraded), 0);
        chk("rst_speed2", int'(speed_2_upgraded), 0);
        chk("rst_effect_left", int'(effect_left), 0);
        chk("rst_collected", int'(was_collected), 0);
        @(negedge frame_clk);
        Reset_n = 1'b1;
        c = 0;
        // two simultaneous hits: P1 first (last winner resets to P2), then P2
        for (int r = 0; r < 2; r++) begin
            expect_spawn(c, ev, x, y);
            BallX = 10'(x); BallY = 10'(y); Ball2X = 10'(x); Ball2Y = 10'(y);
            ec = ev + 1;
            push(K_GRANT, ec, (r == 0) ? 1 : 0, (r == 0) ? 0 : 1);
            push(K_END, ec + EF, 0, 0);
            wait_edge(ec);
            park();
            wait_edge(ec + 1);
            chk("collected_one_cycle", int'(was_collected), 0);
            chk("visible_dropped", int'(upgrade_visible), 0);
            c = ec + EF;
        end
        // single P1 hit off-center, full effect countdown
        expect_spawn(c, ev, x, y);
        BallX = 10'(x + 3); BallY = 10'(y);
        ec = ev + 1;
        push(K_GRANT, ec, 1, 0);
        push(K_END, ec + EF, 0, 0);
        wait_edge(ec);
        park();
        for (int i = 0; i <= EF; i++) begin
            wait_edge(ec + i);
            chk("effect_left", int'(effect_left), EF - i);
            chk("speed1_window", int'(speed_1_upgraded), (i < EF) ? 1 : 0);
        end
        c = ec + EF;
        // P2 edge-distance misses, then corner hit, then game_en drop at effect_left=150
        expect_spawn(c, ev, x, y);
        Ball2X = 10'd0; Ball2Y = 10'(y);
        wait_edge(ev + 1);
        chk("miss_far_left_visible", int'(upgrade_visible), 1);
        Ball2X = 10'(x - 9);
        wait_edge(ev + 2);
        chk("miss_x_by_one_visible", int'(upgrade_visible), 1);
        Ball2X = 10'(x - 8); Ball2Y = 10'(y - 9);
        wait_edge(ev + 3);
        chk("miss_y_by_one_visible", int'(upgrade_visible), 1);
        Ball2Y = 10'(y + 8);
        ec = ev + 4;
        push(K_GRANT, ec, 0, 1);
        push(K_END, ec + 151, 0, 0);
        wait_edge(ec);
        park();
        wait_edge(ec + 150);
        chk("effect_left_at_drop", int'(effect_left), 150);
        game_en = 1'b0;
        wait_edge(ec + 151);
        chk("game_en_speed2", int'(speed_2_upgraded), 0);
        chk("game_en_effect_left", int'(effect_left), 0);
        game_en = 1'b1;
        c = ec + 151;
        // asynchronous reset while ACTIVE
        expect_spawn(c, ev, x, y);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_rst_visible", int'(upgrade_visible), 0);
        chk("async_rst_upgx", int'(UpgradeX), 0);
        chk("async_rst_upgy", int'(UpgradeY), 0);
        #1 Reset_n = 1'b1;
        expect_spawn(0, ev, x, y);
        chk("respawn_after_reset_visible", int'(upgrade_visible), 1);
`ifdef UPGRADE_TIMEOUT_EN
        wait_edge(ev + DF - 1);
        chk("timeout_still_visible", int'(upgrade_visible), 1);
        wait_edge(ev + DF);
        chk("timeout_visible", int'(upgrade_visible), 0);
        chk("timeout_no_grant", int'(speed_1_upgraded || speed_2_upgraded), 0);
        chk("timeout_no_collect", int'(was_collected), 0);
        expect_spawn(ev + DF, ev, x, y);
`endif
        wait_edge(ev + 3);
        chk("scoreboard_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
